// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1010 serial pattern detector: state encodings and pattern constants.
package seq_det_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] S1   = 2'd1;
    localparam logic [1:0] S10  = 2'd2;
    localparam logic [1:0] S101 = 2'd3;

    localparam logic [3:0]  PATTERN = 4'b1010;
    localparam int unsigned PAT_LEN = 4;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StS1   = S1,
        StS10  = S10,
        StS101 = S101
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_1010_enable_gen.sv
// Detects 1010 on a qualified serial stream and emits a registered one-cycle enable pulse per match.
module seq_1010_enable_gen
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             overlap_en,
    input  logic             clear_count,
    output logic             enable_out,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state_dbg
);

    state_e state_q;
    state_e state_d;
    logic   enable_q;
    logic   detect;

    always_comb begin
        state_d = state_q;
        detect  = 1'b0;
        if (serial_valid) begin
            unique case (state_q)
                StIdle: state_d = serial_in ? StS1 : StIdle;
                StS1:   state_d = serial_in ? StS1 : StS10;
                StS10:  state_d = serial_in ? StS101 : StIdle;
                StS101: begin
                    if (serial_in) begin
                        state_d = StS1;
                    end else begin
                        detect  = 1'b1;
                        // Overlap keeps the trailing "10" of the match as fresh progress.
                        state_d = overlap_en ? StS10 : StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= detect;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (clear_count),
        .inc    (detect),
        .count  (match_count)
    );

    assign enable_out = enable_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_seq_1010_enable_gen.sv
// Bench for seq_1010_enable_gen: a bit-history model checked every cycle, plus directed literal checks.
module tb_seq_1010_enable_gen;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic       serial_valid;
    logic       overlap_en;
    logic       clear_count;
    logic       enable_out;
    logic [7:0] match_count;
    logic [1:0] state_dbg;
    logic       enable_out2;
    logic [1:0] match_count2;
    logic [1:0] state_dbg2;

    int checks   = 0;
    int failures = 0;

    seq_1010_enable_gen #(.CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .serial_valid(serial_valid),
        .overlap_en  (overlap_en),
        .clear_count (clear_count),
        .enable_out  (enable_out),
        .match_count (match_count),
        .state_dbg   (state_dbg)
    );

    seq_1010_enable_gen #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .serial_valid(serial_valid),
        .overlap_en  (overlap_en),
        .clear_count (clear_count),
        .enable_out  (enable_out2),
        .match_count (match_count2),
        .state_dbg   (state_dbg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: keep the valid-bit history; a match is 1010 as its newest suffix.
    logic [3:0] hist;
    int         avail;
    bit         model_ok = 0;
    int         exp_en;
    int         exp_cnt8;
    int         exp_cnt2;

    function automatic int exp_state(input logic [3:0] h, input int n);
        // Longest pattern prefix (max 3 bits) that ends the history.
        if (n >= 3 && h[2:0] == 3'b101) return 3;
        if (n >= 2 && h[1:0] == 2'b10)  return 2;
        if (n >= 1 && h[0] == 1'b1)     return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            hist     = 4'b0;
            avail    = 0;
            exp_en   = 0;
            exp_cnt8 = 0;
            exp_cnt2 = 0;
            model_ok = 1;
        end else begin
            int det;
            det = 0;
            if (serial_valid) begin
                hist  = {hist[2:0], serial_in};
                avail = (avail < 4) ? avail + 1 : 4;
                if (avail == 4 && hist == 4'b1010) begin
                    det = 1;
                    if (!overlap_en) avail = 0;
                end
            end
            exp_en = det;
            if (clear_count) begin
                exp_cnt8 = 0;
                exp_cnt2 = 0;
            end else if (det == 1) begin
                exp_cnt8 = (exp_cnt8 < 255) ? exp_cnt8 + 1 : 255;
                exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("enable_out", int'(enable_out), exp_en);
            check("match_count", int'(match_count), exp_cnt8);
            check("state_dbg", int'(state_dbg), exp_state(hist, avail));
            check("enable_out_w2", int'(enable_out2), exp_en);
            check("match_count_w2", int'(match_count2), exp_cnt2);
        end
    end

    task automatic cyc(input logic v, input logic b);
        serial_valid = v;
        serial_in    = b;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        serial_valid = 1'b0;
        serial_in    = 1'b0;
        clear_count  = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    int pulses;

    initial begin
        reset_n      = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        overlap_en   = 1'b1;
        clear_count  = 1'b0;

        // T1: basic detection
        do_reset();
        check("t1_reset_en", int'(enable_out), 0);
        check("t1_reset_cnt", int'(match_count), 0);
        check("t1_reset_state", int'(state_dbg), 0);
        cyc(1, 1); cyc(1, 0); cyc(1, 1);
        check("t1_no_early_pulse", int'(enable_out), 0);
        check("t1_state_s101", int'(state_dbg), 3);
        cyc(1, 0);
        check("t1_pulse", int'(enable_out), 1);
        check("t1_cnt", int'(match_count), 1);
        check("t1_state", int'(state_dbg), 2);
        cyc(0, 0);
        check("t1_pulse_one_cycle", int'(enable_out), 0);

        // T2: overlap vs non-overlap on 101010
        do_reset();
        overlap_en = 1'b1;
        cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 0);
        check("t2o_pulse1", int'(enable_out), 1);
        cyc(1, 1);
        check("t2o_gap", int'(enable_out), 0);
        cyc(1, 0);
        check("t2o_pulse2", int'(enable_out), 1);
        check("t2o_cnt", int'(match_count), 2);
        do_reset();
        overlap_en = 1'b0;
        cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 0);
        check("t2n_pulse", int'(enable_out), 1);
        check("t2n_state", int'(state_dbg), 0);
        cyc(1, 1); cyc(1, 0);
        check("t2n_no_pulse2", int'(enable_out), 0);
        check("t2n_cnt", int'(match_count), 1);
        overlap_en = 1'b1;

        // T3: valid gaps between bits
        do_reset();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, (i % 2 == 0) ? 1'b1 : 1'b0);
            pulses += int'(enable_out);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(0, 1'b0);
                    pulses += int'(enable_out);
                end
            end
        end
        check("t3_final_pulse", int'(enable_out), 1);
        check("t3_pulses", pulses, 1);

        // T4: near misses 1100 and 1011 before a real match
        do_reset();
        pulses = 0;
        begin
            logic [10:0] s4;
            s4 = 11'b11001011010;
            for (int i = 10; i >= 0; i--) begin
                cyc(1, s4[i]);
                pulses += int'(enable_out);
            end
        end
        check("t4_last_pulse", int'(enable_out), 1);
        check("t4_pulses", pulses, 1);

        // T5: saturation at CNT_W=2, then clear on the detect edge
        do_reset();
        cyc(1, 1); cyc(1, 0); cyc(1, 1);
        begin
            int exp5 [5];
            exp5 = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 5; i++) begin
                cyc(1, 0);
                check("t5_pulse", int'(enable_out2), 1);
                check("t5_sat_cnt", int'(match_count2), exp5[i]);
                cyc(1, 1);
            end
        end
        check("t5_wide_cnt", int'(match_count), 5);
        clear_count = 1'b1;
        cyc(1, 0);
        clear_count = 1'b0;
        check("t5_clr_pulse", int'(enable_out), 1);
        check("t5_clr_cnt", int'(match_count), 0);
        check("t5_clr_cnt_w2", int'(match_count2), 0);

        // T6: reset mid-pattern discards progress
        do_reset();
        cyc(1, 1); cyc(1, 0); cyc(1, 1);
        reset_n = 1'b0;
        cyc(1, 0);
        reset_n = 1'b1;
        check("t6_rst_no_pulse", int'(enable_out), 0);
        check("t6_rst_state", int'(state_dbg), 0);
        check("t6_rst_cnt", int'(match_count), 0);
        pulses = 0;
        cyc(1, 0); pulses += int'(enable_out);
        cyc(1, 1); pulses += int'(enable_out);
        cyc(1, 0); pulses += int'(enable_out);
        check("t6_no_pulse", pulses, 0);
        check("t6_state", int'(state_dbg), 2);
        cyc(0, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
